// File: rtl/uart_baud_ctrl.sv
// Baud divisor configuration for the UART divider: shadow/active divisor registers with an
// idle-gated apply, plus an autobaud FSM that measures one start-bit width on uart_rxd.
module uart_baud_ctrl #(
  parameter logic [11:0] DEF_TX     = 12'd433,
  parameter logic [8:0]  DEF_RX     = 9'd26,
  parameter logic [23:0] AB_TIMEOUT = 24'd10000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic [15:0] cfg_rdata,
  input  logic        uart_rxd,
  input  logic        tx_idle,
  input  logic        rx_idle,
  output logic [11:0] tx_cnt,
  output logic [8:0]  rx_cnt,
  output logic        ab_busy,
  output logic        irq
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_HIGH = 3'd1;
  localparam logic [2:0] S_WAIT_FALL = 3'd2;
  localparam logic [2:0] S_MEASURE   = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;
  localparam logic [2:0] S_DONE_OK   = 3'd5;
  localparam logic [2:0] S_DONE_ERR  = 3'd6;

  logic [2:0]  state;
  logic [11:0] sh_tx;
  logic [8:0]  sh_rx;
  logic        pending, ab_done, ab_err;
  logic        rxd_m, rxd_s;
  logic [23:0] tcnt;
  logic [15:0] bcnt;

  logic        wr_ctrl, commit, ab_start, ab_clear, wr_tx, wr_rx, apply;
  logic        b_ok, timeout, ab_ok;
  logic [11:0] ab_tx;
  logic [8:0]  ab_rx;
  logic        unused_bits;

  assign ab_busy  = (state != S_IDLE);
  assign wr_ctrl  = cfg_we && (cfg_addr == 2'd2);
  assign commit   = wr_ctrl && cfg_wdata[0];
  assign ab_start = wr_ctrl && cfg_wdata[1] && (state == S_IDLE);
  assign ab_clear = wr_ctrl && cfg_wdata[2];
  assign wr_tx    = cfg_we && (cfg_addr == 2'd0) && !ab_busy;
  assign wr_rx    = cfg_we && (cfg_addr == 2'd1) && !ab_busy;
  assign apply    = pending && tx_idle && rx_idle;
  assign b_ok     = (bcnt >= 16'd32) && (bcnt <= 16'd8192);
  assign timeout  = (tcnt == AB_TIMEOUT - 24'd1);
  assign ab_ok    = (state == S_CHECK) && b_ok;
  // B is at most 8192 when accepted, so these slices hold B>>1 and B>>5 modulo the divisor widths
  assign ab_tx    = bcnt[12:1] - 12'd1;
  assign ab_rx    = bcnt[13:5] - 9'd1;
  assign unused_bits = ^cfg_wdata[15:12];

  always_comb begin
    cfg_rdata = 16'h0000;
    case (cfg_addr)
      2'd0:    cfg_rdata = {4'b0, sh_tx};
      2'd1:    cfg_rdata = {7'b0, sh_rx};
      2'd3:    cfg_rdata = {12'b0, pending, ab_err, ab_done, ab_busy};
      default: cfg_rdata = 16'h0000;
    endcase
  end

  // rx line idles high, so the synchronizer resets to 1 to avoid a false falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt  <= DEF_TX;
      rx_cnt  <= DEF_RX;
      sh_tx   <= DEF_TX;
      sh_rx   <= DEF_RX;
      pending <= 1'b0;
    end else begin
      if (apply) begin
        tx_cnt <= sh_tx;
        rx_cnt <= sh_rx;
      end
      // a fresh commit wins over the apply that consumes the previous one
      if (commit || ab_ok) pending <= 1'b1;
      else if (apply)      pending <= 1'b0;
      if (ab_ok) begin
        sh_tx <= ab_tx;
        sh_rx <= ab_rx;
      end else begin
        if (wr_tx) sh_tx <= cfg_wdata[11:0];
        if (wr_rx) sh_rx <= cfg_wdata[8:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tcnt    <= 24'd0;
      bcnt    <= 16'd0;
      ab_done <= 1'b0;
      ab_err  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (ab_clear) begin
        ab_done <= 1'b0;
        ab_err  <= 1'b0;
      end
      case (state)
        S_IDLE: if (ab_start) begin
          state   <= S_WAIT_HIGH;
          ab_done <= 1'b0;
          ab_err  <= 1'b0;
        end
        S_WAIT_HIGH: begin
          tcnt <= 24'd0;
          if (rxd_s) state <= S_WAIT_FALL;
        end
        S_WAIT_FALL: begin
          if (!rxd_s) begin
            state <= S_MEASURE;
            bcnt  <= 16'd1;
          end else if (timeout) begin
            state  <= S_DONE_ERR;
            ab_err <= 1'b1;
            irq    <= 1'b1;
          end else begin
            tcnt <= tcnt + 24'd1;
          end
        end
        S_MEASURE: begin
          if (rxd_s)                  state <= S_CHECK;
          else if (bcnt != 16'hFFFF)  bcnt  <= bcnt + 16'd1;
        end
        S_CHECK: begin
          irq <= 1'b1;
          if (b_ok) begin
            state   <= S_DONE_OK;
            ab_done <= 1'b1;
          end else begin
            state  <= S_DONE_ERR;
            ab_err <= 1'b1;
          end
        end
        S_DONE_OK, S_DONE_ERR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
